// File: rtl/router_pkg.sv
// router_pkg: flit layout, port indices and output-stage states shared across the router.
package router_pkg;
    localparam int FLIT_W = 64;
    localparam int X_LSB = 32;
    localparam int Y_LSB = 48;
    localparam int DATA_W = 32;
    localparam int NUM_PORTS = 5;
    localparam int P_LEFT = 0;
    localparam int P_RIGHT = 1;
    localparam int P_UP = 2;
    localparam int P_DOWN = 3;
    localparam int P_CPU = 4;
    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
        logic [DATA_W-1:0] data;
    } flit_t;
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/router_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first requester at or after ptr with wrap.
module rr_pick import router_pkg::*; #(
    parameter int N = NUM_PORTS,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);
    logic [IDW-1:0] j;
    always_comb begin
        j = '0;
        idx = '0;
        // Scan farthest-first so the closest requester to ptr overwrites last.
        for (int k = N - 1; k >= 0; k--) begin
            j = IDW'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
        any = |req;
        grant = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/router_port_arbiter.sv
// router_port_arbiter: round-robin output-link arbiter with one registered slot; ARB_GRANT_CNT_EN adds grant counters.
module router_port_arbiter import router_pkg::*; #(
    parameter int N = NUM_PORTS,
    parameter int W = FLIT_W,
    parameter int IDW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] in_flit,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_flit,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IDW-1:0] out_src
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [N*16-1:0] grant_cnt
`endif
);
    state_t state, state_next;
    logic [IDW-1:0] rr_ptr, idx;
    logic [N-1:0] grant;
    logic any, free, accept;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req(req),
        .ptr(rr_ptr),
        .grant(grant),
        .idx(idx),
        .any(any)
    );

    // A pop this cycle frees the slot for a same-cycle push.
    assign free = ~out_valid | out_ready;
    assign accept = free & any & ~rst;
    assign in_ready = accept ? grant : '0;
    assign out_valid = state == FULL;

    always_comb begin
        state_next = accept ? FULL : (out_ready ? EMPTY : state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            out_flit <= '0;
            out_src <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                out_flit <= in_flit[idx*W +: W];
                out_src <= idx;
                rr_ptr <= (idx == IDW'(N - 1)) ? '0 : idx + IDW'(1);
            end
        end
    end

`ifdef ARB_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) grant_cnt <= '0;
        else
            for (int k = 0; k < N; k++)
                if (accept && idx == IDW'(k) && grant_cnt[k*16 +: 16] != 16'hFFFF)
                    grant_cnt[k*16 +: 16] <= grant_cnt[k*16 +: 16] + 16'd1;
    end
`endif
endmodule

// File: tb/tb_router_port_arbiter.sv
// tb_router_port_arbiter: directed and random checks against a cycle-level behavioural model.
module tb_router_port_arbiter;
    import router_pkg::*;
    localparam int N = NUM_PORTS;
    localparam int W = FLIT_W;
    localparam int IDW = 3;

    logic clk = 0, rst = 1, out_ready = 1;
    logic [N-1:0] req = '0, in_ready;
    logic [N*W-1:0] in_flit = '0;
    logic [W-1:0] out_flit;
    logic out_valid;
    logic [IDW-1:0] out_src;
`ifdef ARB_GRANT_CNT_EN
    logic [N*16-1:0] grant_cnt;
`endif

    router_port_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .in_flit(in_flit),
        .in_ready(in_ready),
        .out_flit(out_flit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_src(out_src)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the slot is just a valid bit plus the last loaded flit/source.
    bit m_valid = 0;
    logic [W-1:0] m_flit = '0;
    int m_src = 0, m_ptr = 0;
    int grants[$];

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        w = pick(req, m_ptr);
        if (rst) begin
            m_valid = 0; m_flit = '0; m_src = 0; m_ptr = 0;
        end else if ((!m_valid || out_ready) && w >= 0) begin
            m_valid = 1;
            m_flit = in_flit[w*W +: W];
            m_src = w;
            m_ptr = (w + 1) % N;
            grants.push_back(w);
        end else if (out_ready) m_valid = 0;
    end

    always @(negedge clk) begin
        int w;
        logic [N-1:0] e;
        w = pick(req, m_ptr);
        e = (!rst && (!m_valid || out_ready) && w >= 0) ? N'(1) << w : '0;
        chk("in_ready", in_ready, e);
        chk("out_valid", out_valid, m_valid);
        chk("out_flit", out_flit, m_flit);
        chk("out_src", out_src, m_src);
    end

    task automatic set_flit(input int i, input logic [W-1:0] v);
        in_flit[i*W +: W] = v;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_rr[6] = '{0, 1, 2, 3, 4, 0};
        int cnt[N];
        logic [N-1:0] ir;
        req = '1;
        for (int i = 0; i < N; i++) set_flit(i, {16'h1, 16'h2, 32'h100 + i});
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
        end
        rst = 0;
        grants.delete();
        #1 chk("first_grant", in_ready, 5'b00001);
        repeat (6) cyc();
        chk("rr_count", grants.size(), 6);
        for (int k = 0; k < 6; k++) chk("rr_order", grants[k], exp_rr[k]);
        chk("rr_out_flit", out_flit, {16'h1, 16'h2, 32'h100});
        chk("rr_out_valid", out_valid, 1);

        rst = 1; cyc(); rst = 0;
        grants.delete();
        req = 5'b00100; cyc();
        req = 5'b00101; cyc();
        req = 5'b00100; cyc();
        req = '0;
        chk("skip_count", grants.size(), 3);
        chk("skip_g0", grants[0], 2);
        chk("skip_g1", grants[1], 0);
        chk("skip_g2", grants[2], 2);
        chk("skip_model_ptr", m_ptr, 3);
        req = '1;
        #1 chk("skip_next", in_ready, 5'b01000);
        req = '0;
        cyc();

        rst = 1; cyc(); rst = 0;
        set_flit(4, 64'h0001_0002_DEAD_BEEF);
        req = 5'b10000; cyc();
        set_flit(4, 64'h0001_0002_CAFE_F00D);
        out_ready = 0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_flit", out_flit, 64'h0001_0002_DEAD_BEEF);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1;
        #1 chk("bp_release", in_ready, 5'b10000);
        cyc();
        req = '0;
        chk("bp_new_flit", out_flit, 64'h0001_0002_CAFE_F00D);
        chk("bp_new_valid", out_valid, 1);
        chk("bp_new_src", out_src, 4);
        cyc();

        set_flit(1, 64'h0005_0006_0000_0011);
        req = 5'b00010; cyc();
        req = '0;
        chk("pop_valid", out_valid, 1);
        chk("pop_src", out_src, 1);
        cyc();
        chk("pop_drop", out_valid, 0);
        chk("pop_hold_flit", out_flit, 64'h0005_0006_0000_0011);
        chk("pop_hold_src", out_src, 1);

        rst = 1; cyc(); rst = 0;
        grants.delete();
        req = '1;
        repeat (10) cyc();
        req = '0;
        cnt = '{default: 0};
        foreach (grants[k]) cnt[grants[k]]++;
        for (int i = 0; i < N; i++) chk("fair_count", cnt[i], 2);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ir = in_ready;
            cyc();
            for (int i = 0; i < N; i++) begin
                if (ir[i]) req[i] = 1'($urandom_range(0, 1));
                else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
                if (ir[i] || !req[i]) set_flit(i, {$urandom, $urandom});
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 0; req = '0; out_ready = 1;
        cyc();

`ifdef ARB_GRANT_CNT_EN
        rst = 1; cyc(); rst = 0;
        req = 5'b00100;
        repeat (1000) cyc();
        chk("cnt_1000", grant_cnt[2*16 +: 16], 16'd1000);
        repeat (69000) cyc();
        req = '0;
        for (int i = 0; i < N; i++)
            chk("cnt_sat", grant_cnt[i*16 +: 16], (i == 2) ? 16'hFFFF : 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/router_port_arbiter.md
Name: router_port_arbiter

Overview:
- Clocked round-robin arbiter that shares one mesh-router output link (left/right/up/down/to-cpu) between the router's five input sources.
- Packet format: 64-bit flit {y[63:48], x[47:32], data[31:0]}. Each flit is a complete single-flit packet, so no wormhole lock is needed.
- One instance sits in front of each router output port. The route-compute logic upstream asserts req toward this port only for flits whose XY route selects it.
- A one-deep registered output stage decouples arbitration from the downstream valid/ready link.

Parameters:
- N, 5, number of requesters. Index 0=left, 1=right, 2=up, 3=down, 4=cpu.
- W, 64, flit width in bits.
- IDW, 3, width of the grant index; must satisfy 2**IDW >= N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  per-requester flit valid.
- in_flit  input  N*W  flattened flits; requester i occupies bits [i*W +: W].
- in_ready  output  N  one-hot accept; the flit is consumed when req[i] & in_ready[i].
- out_flit  output  W  registered winning flit.
- out_valid  output  1  out_flit holds an unconsumed flit.
- out_ready  input  1  downstream accepts; the transfer happens when out_valid & out_ready.
- out_src  output  IDW  index of the requester that supplied out_flit.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_flit=0, out_src=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready is forced to all-zero while rst=1.
  - Any flit held in the output stage is dropped.
- Slot free:
  - free = ~out_valid | out_ready.
  - This is same-cycle pass-through of the pop; no bubble on a back-to-back stream.
- Arbitration (combinational):
  - Search starts at rr_ptr and proceeds in increasing index order, wrapping N-1 -> 0.
  - Winner = first i with req[i]=1.
  - in_ready = onehot(winner) when free and any req; otherwise 0.
  - At most one in_ready bit is high in any cycle.
- Accept (clk edge with a handshake on the winner):
  - out_flit <= in_flit[winner], out_src <= winner, out_valid <= 1.
  - rr_ptr <= (winner+1) mod N; wrap from N-1 gives 0.
  - Latency is 1 cycle from accept to out_valid.
- Pop without a new accept: out_valid <= 0. out_flit and out_src hold their last values.
- No request, or slot not free: rr_ptr unchanged. Requesters must hold req and in_flit stable until accepted.
- State machine, 2 states:
  - EMPTY (out_valid=0): goes to FULL on an accept.
  - FULL (out_valid=1):
    - out_ready & accept -> stay FULL, new flit loaded.
    - out_ready & ~accept -> EMPTY.
    - ~out_ready -> stay FULL; out_flit and out_src stable, in_ready=0.
- Fairness: with all N requesters continuously active, each is granted exactly once per N accepts.
- Simultaneous pop and push in FULL: both occur in the same cycle. Throughput is one flit per cycle.
- Reset mid-stall: a held flit is lost and no in_ready is issued during reset. Upstream retransmission is out of scope.

Optional Feature:
- Macro: ARB_GRANT_CNT_EN.
- When defined:
  - Adds output grant_cnt [N*16-1:0]: one 16-bit saturating counter per requester.
  - Counter i increments on each accept from requester i and holds at 16'hFFFF.
  - All counters clear on rst.
- When undefined: the port and the counters are absent. Arbitration behaviour is identical in both builds.

Decomposition:
- Shared package router_pkg holds:
  - constants FLIT_W=64, X_LSB=32, Y_LSB=48, DATA_W=32, NUM_PORTS=5;
  - port index constants P_LEFT=0, P_RIGHT=1, P_UP=2, P_DOWN=3, P_CPU=4;
  - a flit typedef with fields y, x, data.
- One natural sub-module: rr_pick.
  - Purely combinational.
  - Inputs: req and rr_ptr. Outputs: onehot grant, winner index, any.
  - Reused by future input-side schedulers.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with req=5'b11111.
  - Required: in_ready=0, out_valid=0; after release, the first accept is requester 0.
- Round-robin:
  - Stimulus: req=5'b11111 held, out_ready=1, in_flit[i]={16'h1,16'h2,32'h100+i}.
  - Required: out_src sequence 0,1,2,3,4,0; out_valid high every cycle after the first.
- Pointer skip:
  - Stimulus: rr_ptr=3 after granting 2, then req=5'b00101.
  - Required: grant 0 (wraps past 3,4), then 2; rr_ptr ends at 3.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles with req[4]=1 and flit 64'h0001_0002_DEAD_BEEF loaded.
  - Required: out_flit stable, in_ready=0 throughout.
  - Then out_ready=1: pop and accept of the next flit occur in the same cycle.
- Pop/no-push:
  - Stimulus: single flit from requester 1, then req=0 with out_ready=1.
  - Required: out_valid drops to 0 exactly one cycle after the pop.
- Counters (ARB_GRANT_CNT_EN):
  - Stimulus: 70000 grants to requester 2.
  - Required: grant_cnt[2] saturates at 16'hFFFF; other counters stay 0.
